// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcode constants and default datapath width for the
//            execute-stage ALU and its flag unit.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DEFAULT_WIDTH = 64;

  // cntrl encodings; 3'b001 and 3'b111 are unused and produce a zero result.
  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/dff_var.sv
`default_nettype none
// ============================================================================
// Module   : dff_var
// Purpose  : Parameterised enable-gated register with synchronous reset.
//            Reset clears the register and takes priority over enable.
// Ports    : clk    - rising-edge clock
//            reset  - synchronous active-high clear
//            enable - load enable for d
//            d      - next value [SIZE-1:0]
//            q      - registered value [SIZE-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module dff_var #(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  logic [SIZE-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (enable) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : dff_var
`default_nettype wire

// File: rtl/alu_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_flag_unit
// Purpose  : EX-stage ALU with an always-loading result register and four
//            enable-gated condition-flag registers. A bypass mux lets a
//            consumer see the live flags of the instruction now in EX.
// Ports    : clk, reset                  - clock, synchronous active-high reset
//            a, b [WIDTH-1:0]            - operands
//            cntrl [2:0]                 - operation select (see alu_pkg)
//            set_flag                    - load enable for flag registers
//            flag_bypass                 - 1: live flags out, 0: registered
//            result [WIDTH-1:0]          - combinational ALU result
//            *_live                      - combinational flags (N Z V C)
//            result_q [WIDTH-1:0]        - result registered every cycle
//            negative, zero, overflow, cout - selected flags
// Revision : 1.0 - initial release
// ============================================================================
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cntrl,
  input  logic             set_flag,
  input  logic             flag_bypass,
  output logic [WIDTH-1:0] result,
  output logic             negative_live,
  output logic             zero_live,
  output logic             overflow_live,
  output logic             carry_live,
  output logic [WIDTH-1:0] result_q,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             cout
);

  // --------------------------------------------------------------------------
  // Shared adder: subtraction is A + ~B + 1.
  // --------------------------------------------------------------------------
  logic             w_is_sub;
  logic             w_is_arith;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_add;
  logic             w_carry_msb_in;

  assign w_is_sub   = (cntrl == ALU_SUB);
  assign w_is_arith = (cntrl == ALU_ADD) || w_is_sub;
  assign w_b_op     = w_is_sub ? ~b : b;
  assign w_add      = {1'b0, a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};

  // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
  assign w_carry_msb_in = w_add[WIDTH-1] ^ a[WIDTH-1] ^ w_b_op[WIDTH-1];

  always_comb begin
    result = '0;
    case (cntrl)
      ALU_PASS_B: result = b;
      ALU_ADD,
      ALU_SUB:    result = w_add[WIDTH-1:0];
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      default:    result = '0;
    endcase
  end

  assign negative_live = result[WIDTH-1];
  assign zero_live     = (result == '0);
  assign carry_live    = w_is_arith & w_add[WIDTH];
  assign overflow_live = w_is_arith & (w_carry_msb_in ^ w_add[WIDTH]);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic w_neg_q;
  logic w_zero_q;
  logic w_ovf_q;
  logic w_carry_q;

  dff_var #(.SIZE(WIDTH)) u_result_reg (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .d      (result),
    .q      (result_q)
  );

  dff_var #(.SIZE(1)) u_neg_reg (
    .clk    (clk),
    .reset  (reset),
    .enable (set_flag),
    .d      (negative_live),
    .q      (w_neg_q)
  );

  dff_var #(.SIZE(1)) u_zero_reg (
    .clk    (clk),
    .reset  (reset),
    .enable (set_flag),
    .d      (zero_live),
    .q      (w_zero_q)
  );

  dff_var #(.SIZE(1)) u_ovf_reg (
    .clk    (clk),
    .reset  (reset),
    .enable (set_flag),
    .d      (overflow_live),
    .q      (w_ovf_q)
  );

  dff_var #(.SIZE(1)) u_carry_reg (
    .clk    (clk),
    .reset  (reset),
    .enable (set_flag),
    .d      (carry_live),
    .q      (w_carry_q)
  );

  // Output select only; never feeds back into the registers.
  assign negative = flag_bypass ? negative_live : w_neg_q;
  assign zero     = flag_bypass ? zero_live     : w_zero_q;
  assign overflow = flag_bypass ? overflow_live : w_ovf_q;
  assign cout     = flag_bypass ? carry_live    : w_carry_q;

endmodule : alu_flag_unit
`default_nettype wire

// File: tb/tb_alu_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_flag_unit
// Purpose  : Directed self-checking bench for alu_flag_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_flag_unit;
  import alu_pkg::*;

  localparam int WIDTH = 64;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       cntrl;
  logic             set_flag;
  logic             flag_bypass;
  logic [WIDTH-1:0] result;
  logic             negative_live;
  logic             zero_live;
  logic             overflow_live;
  logic             carry_live;
  logic [WIDTH-1:0] result_q;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             cout;

  int n_cmp;
  int n_fail;

  alu_flag_unit #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .a             (a),
    .b             (b),
    .cntrl         (cntrl),
    .set_flag      (set_flag),
    .flag_bypass   (flag_bypass),
    .result        (result),
    .negative_live (negative_live),
    .zero_live     (zero_live),
    .overflow_live (overflow_live),
    .carry_live    (carry_live),
    .result_q      (result_q),
    .negative      (negative),
    .zero          (zero),
    .overflow      (overflow),
    .cout          (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; set_flag = 1'b1; flag_bypass = 1'b0;
    a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; cntrl = ALU_ADD;
    tick(); tick();
    reset = 1'b0; set_flag = 1'b0; #1;
    n_cmp++;
    if (result_q !== 64'd0) begin
      n_fail++; $display("FAIL reset_result_q: got %h want %h", result_q, 64'd0);
    end
    n_cmp++;
    if ({negative, zero, overflow, cout} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want %b", {negative, zero, overflow, cout}, 4'b0000);
    end
  endtask

  task automatic test_add_overflow();
    a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; cntrl = ALU_ADD;
    set_flag = 1'b0; flag_bypass = 1'b0; #1;
    n_cmp++;
    if (result !== 64'h8000_0000_0000_0000) begin
      n_fail++; $display("FAIL add_ovf_result: got %h want %h", result, 64'h8000_0000_0000_0000);
    end
    n_cmp++;
    if ({negative_live, zero_live, overflow_live, carry_live} !== 4'b1010) begin
      n_fail++; $display("FAIL add_ovf_live_nzvc: got %b want %b",
                         {negative_live, zero_live, overflow_live, carry_live}, 4'b1010);
    end
    tick();
    n_cmp++;
    if (result_q !== 64'h8000_0000_0000_0000) begin
      n_fail++; $display("FAIL add_ovf_result_q: got %h want %h", result_q, 64'h8000_0000_0000_0000);
    end
    // set_flag was 0, so registered flags must still hold reset values
    n_cmp++;
    if ({negative, zero, overflow, cout} !== 4'b0000) begin
      n_fail++; $display("FAIL add_ovf_no_load: got %b want %b", {negative, zero, overflow, cout}, 4'b0000);
    end
  endtask

  task automatic test_add_carry_wrap();
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; cntrl = ALU_ADD; #1;
    n_cmp++;
    if ({result, negative_live, zero_live, overflow_live, carry_live} !== {64'd0, 4'b0101}) begin
      n_fail++; $display("FAIL add_wrap: got %h/%b want %h/%b", result,
                         {negative_live, zero_live, overflow_live, carry_live}, 64'd0, 4'b0101);
    end
    // Most negative minus one: signed overflow, no borrow
    a = 64'h8000_0000_0000_0000; b = 64'd1; cntrl = ALU_SUB; #1;
    n_cmp++;
    if ({result, negative_live, zero_live, overflow_live, carry_live}
        !== {64'h7FFF_FFFF_FFFF_FFFF, 4'b0011}) begin
      n_fail++; $display("FAIL sub_ovf: got %h/%b want %h/%b", result,
                         {negative_live, zero_live, overflow_live, carry_live},
                         64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
    end
  endtask

  task automatic test_sub_equal();
    a = 64'd5; b = 64'd5; cntrl = ALU_SUB; set_flag = 1'b1; flag_bypass = 1'b0; #1;
    n_cmp++;
    if ({result, negative_live, zero_live, overflow_live, carry_live} !== {64'd0, 4'b0101}) begin
      n_fail++; $display("FAIL sub_eq_live: got %h/%b want %h/%b", result,
                         {negative_live, zero_live, overflow_live, carry_live}, 64'd0, 4'b0101);
    end
    tick();
    n_cmp++;
    if ({negative, zero, overflow, cout} !== 4'b0101) begin
      n_fail++; $display("FAIL sub_eq_reg_flags: got %b want %b", {negative, zero, overflow, cout}, 4'b0101);
    end
  endtask

  task automatic test_flag_hold();
    a = 64'd3; b = 64'd5; cntrl = ALU_SUB; set_flag = 1'b0; flag_bypass = 1'b0; #1;
    n_cmp++;
    if ({result, negative_live, zero_live, overflow_live, carry_live}
        !== {64'hFFFF_FFFF_FFFF_FFFE, 4'b1000}) begin
      n_fail++; $display("FAIL hold_live: got %h/%b want %h/%b", result,
                         {negative_live, zero_live, overflow_live, carry_live},
                         64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({negative, zero, overflow, cout} !== 4'b0101) begin
        n_fail++; $display("FAIL hold_edge%0d: got %b want %b", i, {negative, zero, overflow, cout}, 4'b0101);
      end
    end
  endtask

  task automatic test_bypass();
    flag_bypass = 1'b1; #1;
    n_cmp++;
    if ({negative, zero, overflow, cout} !== 4'b1000) begin
      n_fail++; $display("FAIL bypass_live: got %b want %b", {negative, zero, overflow, cout}, 4'b1000);
    end
    flag_bypass = 1'b0; #1;
    n_cmp++;
    if ({negative, zero, overflow, cout} !== 4'b0101) begin
      n_fail++; $display("FAIL bypass_off: got %b want %b", {negative, zero, overflow, cout}, 4'b0101);
    end
  endtask

  task automatic test_logic_ops();
    logic [2:0]       ops [6];
    logic [WIDTH-1:0] exp [6];
    logic [3:0]       fl  [6];
    ops[0] = ALU_AND;    exp[0] = 64'h00F0; fl[0] = 4'b0000;
    ops[1] = ALU_OR;     exp[1] = 64'hFFF0; fl[1] = 4'b0000;
    ops[2] = ALU_XOR;    exp[2] = 64'hFF00; fl[2] = 4'b0000;
    ops[3] = ALU_PASS_B; exp[3] = 64'h0FF0; fl[3] = 4'b0000;
    ops[4] = 3'b111;     exp[4] = 64'h0;    fl[4] = 4'b0100;
    ops[5] = 3'b001;     exp[5] = 64'h0;    fl[5] = 4'b0100;
    a = 64'hF0F0; b = 64'h0FF0; set_flag = 1'b0; flag_bypass = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cntrl = ops[i]; #1;
      n_cmp++;
      if ({result, negative, zero, overflow, cout} !== {exp[i], fl[i]}) begin
        n_fail++; $display("FAIL logic_op_%b: got %h/%b want %h/%b", ops[i], result,
                           {negative, zero, overflow, cout}, exp[i], fl[i]);
      end
    end
    flag_bypass = 1'b0;
  endtask

  task automatic test_set_and_bypass();
    a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; cntrl = ALU_ADD;
    set_flag = 1'b1; flag_bypass = 1'b1; #1;
    n_cmp++;
    if ({negative, zero, overflow, cout} !== 4'b1010) begin
      n_fail++; $display("FAIL setbyp_now: got %b want %b", {negative, zero, overflow, cout}, 4'b1010);
    end
    tick();
    set_flag = 1'b0; flag_bypass = 1'b0; cntrl = ALU_PASS_B; b = 64'd0; #1;
    n_cmp++;
    if ({negative, zero, overflow, cout} !== 4'b1010) begin
      n_fail++; $display("FAIL setbyp_reg: got %b want %b", {negative, zero, overflow, cout}, 4'b1010);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] prev;
    logic [2:0]       ops [4];
    logic [WIDTH-1:0] av  [4];
    logic [WIDTH-1:0] bv  [4];
    logic [WIDTH-1:0] ev  [4];
    ops[0] = ALU_ADD; av[0] = 64'd1;   bv[0] = 64'd2;   ev[0] = 64'd3;
    ops[1] = ALU_SUB; av[1] = 64'd10;  bv[1] = 64'd4;   ev[1] = 64'd6;
    ops[2] = ALU_XOR; av[2] = 64'hAA;  bv[2] = 64'h55;  ev[2] = 64'hFF;
    ops[3] = ALU_OR;  av[3] = 64'h100; bv[3] = 64'h001; ev[3] = 64'h101;
    set_flag = 1'b0; flag_bypass = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = av[i]; b = bv[i]; cntrl = ops[i];
      tick();
      n_cmp++;
      if (result_q !== ev[i]) begin
        n_fail++; $display("FAIL b2b_%0d: got %h want %h", i, result_q, ev[i]);
      end
    end
    prev = ev[3];
    n_cmp++;
    if (result_q !== prev) begin
      n_fail++; $display("FAIL b2b_final: got %h want %h", result_q, prev);
    end
  endtask

  task automatic test_reset_mid();
    a = 64'd3; b = 64'd5; cntrl = ALU_SUB; set_flag = 1'b1; flag_bypass = 1'b0;
    tick();
    n_cmp++;
    if ({result_q, negative, zero, overflow, cout} !== {64'hFFFF_FFFF_FFFF_FFFE, 4'b1000}) begin
      n_fail++; $display("FAIL rstmid_pre: got %h/%b want %h/%b", result_q,
                         {negative, zero, overflow, cout}, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({result_q, negative, zero, overflow, cout} !== {64'd0, 4'b0000}) begin
      n_fail++; $display("FAIL rstmid_post: got %h/%b want %h/%b", result_q,
                         {negative, zero, overflow, cout}, 64'd0, 4'b0000);
    end
    reset = 1'b0; set_flag = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_add_overflow();
    test_add_carry_wrap();
    test_sub_equal();
    test_flag_hold();
    test_bypass();
    test_logic_ops();
    test_set_and_bypass();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_alu_flag_unit
`default_nettype wire
